bp_nonsynth_mem_if_monitor: RTL and testbench

//  Nonsynth runtime monitor on the BedRock CCE<->memory stream interface. It is the dynamic companion to the

---
 rtl/bp_nonsynth_mem_if_monitor_pkg.sv | 45 ++++
 rtl/bp_nonsynth_mem_if_monitor_addr_fifo.sv | 51 +++++
 rtl/bp_nonsynth_mem_if_monitor.sv | 149 ++++++++++++++
 tb/tb_bp_nonsynth_mem_if_monitor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_nonsynth_mem_if_monitor_pkg.sv
// Shared types for the CCE<->memory stream monitor: config selector, header layout and violation codes.
package bp_nonsynth_mem_if_monitor_pkg;

   typedef enum logic [1:0] {
      e_bp_default_cfg = 2'd0
   } bp_params_e;

   localparam int paddr_width_gp   = 40;
   localparam int payload_width_gp = 8;

   typedef struct packed {
      logic [3:0]                  msg_type;
      logic [2:0]                  size;
      logic [paddr_width_gp-1:0]   addr;
      logic [payload_width_gp-1:0] payload;
   } bp_bedrock_mem_header_s;

   // addr sits directly above the payload field in the packed header
   localparam int header_addr_lsb_gp = payload_width_gp;

   typedef enum logic [2:0] {
      e_err_none          = 3'd0,
      e_err_cmd_unstable  = 3'd1,
      e_err_resp_unstable = 3'd2,
      e_err_underflow     = 3'd3,
      e_err_overflow      = 3'd4,
      e_err_timeout       = 3'd5,
      e_err_addr_mismatch = 3'd6
   } bp_mem_if_err_e;

   function automatic int bp_paddr_width(bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return paddr_width_gp;
         default:          return paddr_width_gp;
      endcase
   endfunction

   function automatic int bp_header_width(bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return $bits(bp_bedrock_mem_header_s);
         default:          return $bits(bp_bedrock_mem_header_s);
      endcase
   endfunction

endpackage

// File: rtl/bp_nonsynth_mem_if_monitor_addr_fifo.sv
// In-order address FIFO for the monitor's address check; built only with BP_NONSYNTH_MEM_IF_ADDR_CHECK_EN.
`ifdef BP_NONSYNTH_MEM_IF_ADDR_CHECK_EN
module bp_nonsynth_mem_if_addr_fifo
 #(parameter int   width_p        = 40
   ,parameter int  els_p          = 8
   ,localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1
   ,localparam int count_width_lp = $clog2(els_p+1)
   )
  (input  logic               clk
   ,input  logic               reset
   ,input  logic               push
   ,input  logic [width_p-1:0] push_addr
   ,input  logic               pop
   ,output logic [width_p-1:0] head_addr
   ,output logic               empty
   );

   localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(els_p-1);

   logic [width_p-1:0]        mem_q [els_p];
   logic [ptr_width_lp-1:0]   wptr_q, rptr_q;
   logic [count_width_lp-1:0] count_q;

   // Caller never pushes into a full FIFO unless it pops in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push)
            wptr_q <= (wptr_q == ptr_last_lp) ? '0 : wptr_q + 1'b1;
         if (pop)
            rptr_q <= (rptr_q == ptr_last_lp) ? '0 : rptr_q + 1'b1;
         if (push & ~pop)
            count_q <= count_q + 1'b1;
         else if (pop & ~push)
            count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wptr_q] <= push_addr;
   end

   assign head_addr = mem_q[rptr_q];
   assign empty     = (count_q == '0);

endmodule
`endif

// File: rtl/bp_nonsynth_mem_if_monitor.sv
// Passive runtime monitor of the CCE<->memory cmd/resp streams; latches the first protocol violation.
// Optional in-order address check is enabled by defining BP_NONSYNTH_MEM_IF_ADDR_CHECK_EN.
module bp_nonsynth_mem_if_monitor
   import bp_nonsynth_mem_if_monitor_pkg::*;
 #(parameter bp_params_e bp_params_p      = e_bp_default_cfg
   ,parameter int        max_outstanding_p = 8
   ,parameter int        timeout_p         = 1024
   ,parameter bit        report_p          = 1'b1
   ,localparam int       mem_header_width_lp = bp_header_width(bp_params_p)
   ,localparam int       count_width_lp      = $clog2(max_outstanding_p+1)
   )
  (input  logic                           clk_i
   ,input  logic                           reset_i
   ,input  logic [mem_header_width_lp-1:0] mem_cmd_header_i
   ,input  logic                           mem_cmd_v_i
   ,input  logic                           mem_cmd_ready_and_i
   ,input  logic                           mem_cmd_last_i
   ,input  logic [mem_header_width_lp-1:0] mem_resp_header_i
   ,input  logic                           mem_resp_v_i
   ,input  logic                           mem_resp_ready_and_i
   ,input  logic                           mem_resp_last_i
   ,output logic [count_width_lp-1:0]      outstanding_o
   ,output logic                           error_o
   ,output logic [2:0]                     error_code_o
   );

   localparam int timer_width_lp = $clog2(timeout_p+1);
   localparam logic [count_width_lp-1:0] count_max_lp  = count_width_lp'(max_outstanding_p);
   localparam logic [timer_width_lp-1:0] timer_max_lp  = timer_width_lp'(timeout_p);
   localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_p-1);

   // Handshake: a beat transfers when v & ready_and; once v is up without ready, v and header must
   // hold until the transfer. A message completes on the transferring beat that carries last.
   logic cmd_done, resp_done;
   logic cmd_stall_q, resp_stall_q;
   logic [mem_header_width_lp-1:0] cmd_header_q, resp_header_q;
   logic [count_width_lp-1:0] count_q;
   logic [timer_width_lp-1:0] timer_q;
   logic cmd_unstable, resp_unstable, underflow, overflow, timer_run, timeout_hit, addr_mismatch;
   logic error_q;
   bp_mem_if_err_e err_code, error_code_q;

   assign cmd_done  = mem_cmd_v_i  & mem_cmd_ready_and_i  & mem_cmd_last_i;
   assign resp_done = mem_resp_v_i & mem_resp_ready_and_i & mem_resp_last_i;

   assign cmd_unstable  = cmd_stall_q  & (~mem_cmd_v_i  | (mem_cmd_header_i  != cmd_header_q));
   assign resp_unstable = resp_stall_q & (~mem_resp_v_i | (mem_resp_header_i != resp_header_q));
   assign underflow     = resp_done & ~cmd_done  & (count_q == '0);
   assign overflow      = cmd_done  & ~resp_done & (count_q == count_max_lp);
   assign timer_run     = ~resp_done & (count_q != '0);
   assign timeout_hit   = timer_run & (timer_q == timer_last_lp);

`ifdef BP_NONSYNTH_MEM_IF_ADDR_CHECK_EN
   localparam int paddr_width_p = bp_paddr_width(bp_params_p);

   logic [paddr_width_p-1:0] cmd_addr, resp_addr, head_addr, expected_addr;
   logic fifo_empty, fifo_push, fifo_pop, bypass;

   assign cmd_addr  = mem_cmd_header_i[header_addr_lsb_gp +: paddr_width_p];
   assign resp_addr = mem_resp_header_i[header_addr_lsb_gp +: paddr_width_p];

   // FIFO occupancy tracks count_q exactly, so empty plus a resp always means underflow or bypass.
   assign bypass        = cmd_done & resp_done & fifo_empty;
   assign fifo_push     = cmd_done & ~overflow & ~bypass;
   assign fifo_pop      = resp_done & ~underflow & ~fifo_empty;
   assign expected_addr = fifo_empty ? cmd_addr : head_addr;
   assign addr_mismatch = resp_done & ~underflow & (resp_addr != expected_addr);

   bp_nonsynth_mem_if_addr_fifo
    #(.width_p(paddr_width_p)
      ,.els_p(max_outstanding_p)
      )
    addr_fifo
     (.clk(clk_i)
      ,.reset(reset_i)
      ,.push(fifo_push)
      ,.push_addr(cmd_addr)
      ,.pop(fifo_pop)
      ,.head_addr(head_addr)
      ,.empty(fifo_empty)
      );
`else
   assign addr_mismatch = 1'b0;
`endif

   always_comb begin
      err_code = e_err_none;
      if (cmd_unstable)
         err_code = e_err_cmd_unstable;
      else if (resp_unstable)
         err_code = e_err_resp_unstable;
      else if (underflow)
         err_code = e_err_underflow;
      else if (overflow)
         err_code = e_err_overflow;
      else if (timeout_hit)
         err_code = e_err_timeout;
      else if (addr_mismatch)
         err_code = e_err_addr_mismatch;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cmd_stall_q   <= 1'b0;
         resp_stall_q  <= 1'b0;
         cmd_header_q  <= '0;
         resp_header_q <= '0;
         count_q       <= '0;
         timer_q       <= '0;
         error_q       <= 1'b0;
         error_code_q  <= e_err_none;
      end else begin
         cmd_stall_q   <= mem_cmd_v_i  & ~mem_cmd_ready_and_i;
         resp_stall_q  <= mem_resp_v_i & ~mem_resp_ready_and_i;
         cmd_header_q  <= mem_cmd_header_i;
         resp_header_q <= mem_resp_header_i;

         if (cmd_done & ~resp_done & ~overflow)
            count_q <= count_q + 1'b1;
         else if (resp_done & ~cmd_done & ~underflow)
            count_q <= count_q - 1'b1;

         if (!timer_run)
            timer_q <= '0;
         else if (timer_q != timer_max_lp)
            timer_q <= timer_q + 1'b1;

         if (!error_q && (err_code != e_err_none)) begin
            error_q      <= 1'b1;
            error_code_q <= err_code;
         end
      end
   end

   generate
      if (report_p) begin : g_report
         always_ff @(posedge clk_i) begin
            if (!reset_i && !error_q && (err_code != e_err_none))
               $error("bp_nonsynth_mem_if_monitor: violation code=%0d time=%0t cmd_header=%h resp_header=%h",
                      err_code, $time, mem_cmd_header_i, mem_resp_header_i);
         end
      end
   endgenerate

   assign outstanding_o = count_q;
   assign error_o       = error_q;
   assign error_code_o  = error_code_q;

endmodule

// File: tb/tb_bp_nonsynth_mem_if_monitor.sv
// Self-checking bench for bp_nonsynth_mem_if_monitor: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_bp_nonsynth_mem_if_monitor;
   import bp_nonsynth_mem_if_monitor_pkg::*;

   localparam int max_out_lp = 8;
   localparam int timeout_lp = 16;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b0;

   bp_bedrock_mem_header_s cmd_hdr, resp_hdr;
   logic       cmd_v, cmd_ready, cmd_last;
   logic       resp_v, resp_ready, resp_last;
   logic [3:0] outstanding;
   logic       error;
   logic [2:0] error_code;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int  m_count, m_timer, m_code;
   bit  m_err, m_cmd_stall, m_resp_stall;
   bp_bedrock_mem_header_s m_cmd_hdr, m_resp_hdr;
   logic [paddr_width_gp-1:0] exp_addr_q[$];

   always #5 clk_i = ~clk_i;

   bp_nonsynth_mem_if_monitor
    #(.max_outstanding_p(max_out_lp)
      ,.timeout_p(timeout_lp)
      ,.report_p(1'b0)
      )
    dut
     (.clk_i(clk_i)
      ,.reset_i(reset_i)
      ,.mem_cmd_header_i(cmd_hdr)
      ,.mem_cmd_v_i(cmd_v)
      ,.mem_cmd_ready_and_i(cmd_ready)
      ,.mem_cmd_last_i(cmd_last)
      ,.mem_resp_header_i(resp_hdr)
      ,.mem_resp_v_i(resp_v)
      ,.mem_resp_ready_and_i(resp_ready)
      ,.mem_resp_last_i(resp_last)
      ,.outstanding_o(outstanding)
      ,.error_o(error)
      ,.error_code_o(error_code)
      );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bp_bedrock_mem_header_s rand_hdr();
      bp_bedrock_mem_header_s h;
      h.msg_type = 4'($urandom_range(0, 15));
      h.size     = 3'($urandom_range(0, 7));
      h.addr     = {8'h00, 32'($urandom())};
      h.payload  = 8'($urandom_range(0, 255));
      return h;
   endfunction

   task automatic model_reset();
      m_count = 0; m_timer = 0; m_code = 0; m_err = 1'b0;
      m_cmd_stall = 1'b0; m_resp_stall = 1'b0;
      exp_addr_q.delete();
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit cd, rd, uf, of;
      int code, nt;
      cd = cmd_v && cmd_ready && cmd_last;
      rd = resp_v && resp_ready && resp_last;
      code = 0;
      if (m_cmd_stall && (!cmd_v || cmd_hdr != m_cmd_hdr)) code = 1;
      if (code == 0 && m_resp_stall && (!resp_v || resp_hdr != m_resp_hdr)) code = 2;
      uf = rd && !cd && (m_count == 0);
      of = cd && !rd && (m_count == max_out_lp);
      if (rd || m_count == 0) nt = 0;
      else nt = (m_timer < timeout_lp) ? m_timer + 1 : timeout_lp;
      if (code == 0 && uf) code = 3;
      if (code == 0 && of) code = 4;
      if (code == 0 && nt == timeout_lp && m_timer != timeout_lp) code = 5;
      if (cd && !of) exp_addr_q.push_back(cmd_hdr.addr);
      if (rd && !uf) begin
`ifdef BP_NONSYNTH_MEM_IF_ADDR_CHECK_EN
         if (code == 0 && exp_addr_q[0] != resp_hdr.addr) code = 6;
`endif
         void'(exp_addr_q.pop_front());
      end
      if (!uf && !of) m_count = m_count + int'(cd) - int'(rd);
      m_timer = nt;
      if (!m_err && code != 0) begin
         m_err  = 1'b1;
         m_code = code;
      end
      m_cmd_stall  = cmd_v && !cmd_ready;
      m_resp_stall = resp_v && !resp_ready;
      m_cmd_hdr    = cmd_hdr;
      m_resp_hdr   = resp_hdr;
   endtask

   task automatic step();
      model_step();
      @(posedge clk_i);
      #1;
      check_val("outstanding", 32'(outstanding), 32'(m_count));
      check_val("error", 32'(error), 32'(m_err));
      check_val("error_code", 32'(error_code), 32'(m_code));
   endtask

   task automatic idle();
      cmd_v = 1'b0; cmd_last = 1'b0; cmd_ready = 1'b1;
      resp_v = 1'b0; resp_last = 1'b0; resp_ready = 1'b1;
   endtask

   // Called at posedge+1: reset rises mid-cycle and outputs must clear before any clock edge.
   task automatic do_reset();
      idle();
      #1 reset_i = 1'b1;
      #1;
      check_val("async_rst_outstanding", 32'(outstanding), 32'd0);
      check_val("async_rst_error", 32'(error), 32'd0);
      check_val("async_rst_code", 32'(error_code), 32'd0);
      model_reset();
      @(posedge clk_i);
      #1 reset_i = 1'b0;
   endtask

   task automatic send_cmd(input logic [paddr_width_gp-1:0] a);
      cmd_v = 1'b1; cmd_last = 1'b1; cmd_hdr.addr = a;
      step();
      cmd_v = 1'b0; cmd_last = 1'b0;
   endtask

   task automatic send_resp(input logic [paddr_width_gp-1:0] a);
      resp_v = 1'b1; resp_last = 1'b1; resp_hdr.addr = a;
      step();
      resp_v = 1'b0; resp_last = 1'b0;
   endtask

   task automatic rand_drive();
      if (m_cmd_stall) begin
         if ($urandom_range(0, 99) == 0) cmd_v = 1'b0;
         else if ($urandom_range(0, 99) == 0) cmd_hdr.addr = cmd_hdr.addr ^ 40'h40;
      end else begin
         cmd_v    = ($urandom_range(0, 2) == 0);
         cmd_last = ($urandom_range(0, 3) != 0);
         cmd_hdr  = rand_hdr();
      end
      cmd_ready = ($urandom_range(0, 3) != 0);
      if (m_resp_stall) begin
         if ($urandom_range(0, 99) == 0) resp_v = 1'b0;
         else if ($urandom_range(0, 99) == 0) resp_hdr.size = resp_hdr.size ^ 3'h1;
      end else begin
         resp_v    = ($urandom_range(0, 1) == 1) && ((m_count > 0) || ($urandom_range(0, 29) == 0));
         resp_last = ($urandom_range(0, 2) != 0);
         resp_hdr  = rand_hdr();
         if (exp_addr_q.size() > 0 && $urandom_range(0, 39) != 0) resp_hdr.addr = exp_addr_q[0];
      end
      resp_ready = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      cmd_hdr = '0; resp_hdr = '0;
      idle();
      model_reset();
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      do_reset();

      // in-order traffic with ready tied high
      send_cmd(40'h80000000); check_val("seq_cnt_1", 32'(outstanding), 32'd1);
      send_cmd(40'h80000040); check_val("seq_cnt_2", 32'(outstanding), 32'd2);
      send_cmd(40'h80000080); check_val("seq_cnt_3", 32'(outstanding), 32'd3);
      send_resp(40'h80000000); check_val("seq_cnt_4", 32'(outstanding), 32'd2);
      send_resp(40'h80000040); check_val("seq_cnt_5", 32'(outstanding), 32'd1);
      send_resp(40'h80000080); check_val("seq_cnt_6", 32'(outstanding), 32'd0);
      check_val("seq_no_error", 32'(error), 32'd0);

      // same-cycle cmd and resp at count 0, then beats without last
      cmd_v = 1'b1; cmd_last = 1'b1; cmd_hdr.addr = 40'h900;
      resp_v = 1'b1; resp_last = 1'b1; resp_hdr.addr = 40'h900;
      step();
      idle();
      check_val("passthru_cnt", 32'(outstanding), 32'd0);
      check_val("passthru_err", 32'(error), 32'd0);
      cmd_v = 1'b1; resp_v = 1'b1;
      step();
      idle();
      check_val("nolast_cnt", 32'(outstanding), 32'd0);
      check_val("nolast_err", 32'(error), 32'd0);

      // header changes while cmd is stalled
      do_reset();
      cmd_ready = 1'b0; cmd_v = 1'b1; cmd_last = 1'b1; cmd_hdr.addr = 40'h80000000;
      step();
      check_val("unstable_before", 32'(error_code), 32'd0);
      cmd_hdr.addr = 40'h80000040;
      step();
      check_val("unstable_code", 32'(error_code), 32'd1);
      check_val("unstable_err", 32'(error), 32'd1);
      idle();

      // response with nothing outstanding
      do_reset();
      send_resp(40'h80000000);
      check_val("underflow_code", 32'(error_code), 32'd3);
      check_val("underflow_cnt", 32'(outstanding), 32'd0);

      // liveness: one cmd, no resp
      do_reset();
      send_cmd(40'h80000000);
      check_val("timeout_cnt", 32'(outstanding), 32'd1);
      for (int i = 0; i < timeout_lp - 1; i++) step();
      check_val("timeout_early", 32'(error_code), 32'd0);
      step();
      check_val("timeout_code", 32'(error_code), 32'd5);

      // overflow on the ninth cmd
      do_reset();
      for (int i = 0; i < max_out_lp; i++) send_cmd(40'h80000000 + 40'(i * 64));
      check_val("full_cnt", 32'(outstanding), 32'd8);
      check_val("full_code", 32'(error_code), 32'd0);
      send_cmd(40'h80000400);
      check_val("overflow_code", 32'(error_code), 32'd4);
      check_val("overflow_cnt", 32'(outstanding), 32'd8);

`ifdef BP_NONSYNTH_MEM_IF_ADDR_CHECK_EN
      do_reset();
      send_cmd(40'h80000000);
      send_cmd(40'h80000040);
      send_resp(40'h80000000);
      check_val("addr_ok_code", 32'(error_code), 32'd0);
      send_resp(40'h80000080);
      check_val("addr_mismatch_code", 32'(error_code), 32'd6);
`endif

      // reset with transactions in flight discards them
      do_reset();
      for (int i = 0; i < 4; i++) send_cmd(40'h80001000 + 40'(i * 64));
      check_val("inflight_cnt", 32'(outstanding), 32'd4);
      do_reset();
      check_val("post_rst_err", 32'(error), 32'd0);
      send_resp(40'h80001000);
      check_val("post_rst_code", 32'(error_code), 32'd3);
      check_val("post_rst_cnt", 32'(outstanding), 32'd0);

      // randomized episodes
      for (int ep = 0; ep < 8; ep++) begin
         do_reset();
         for (int c = 0; c < 250; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            rand_drive();
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
